// File: rtl/psd_band_power_if.sv
// Filter-bank-to-power-estimator link: one frame of eight band samples in,
// serial per-band averaged power out.
`timescale 1ns/1ps
interface psd_band_power_if;
  logic signed [15:0] datain0;
  logic signed [15:0] datain1;
  logic signed [15:0] datain2;
  logic signed [15:0] datain3;
  logic signed [15:0] datain4;
  logic signed [15:0] datain5;
  logic signed [15:0] datain6;
  logic signed [15:0] datain7;
  logic               din_valid;
  logic               restart;
  logic               busy;
  logic        [31:0] power_out;
  logic        [2:0]  power_band;
  logic               power_valid;
  logic               overrun;

  modport master (
    output datain0, datain1, datain2, datain3,
    output datain4, datain5, datain6, datain7,
    output din_valid, restart,
    input  busy, power_out, power_band, power_valid, overrun
  );

  modport slave (
    input  datain0, datain1, datain2, datain3,
    input  datain4, datain5, datain6, datain7,
    input  din_valid, restart,
    output busy, power_out, power_band, power_valid, overrun
  );
endinterface

// File: rtl/psd_band_power.sv
// Per-band power estimator: squares each of eight band samples through one
// shared multiplier, accumulates over 2^LOG2_AVG frames, streams the averages.
//
// state | meaning
// IDLE  | waiting for a frame (din_valid)
// SQ    | eight cycles, band k squared and accumulated on cycle k
`timescale 1ns/1ps
module psd_band_power #(
  parameter int LOG2_AVG = 6
) (
  input logic              clock,
  input logic              reset,
  psd_band_power_if.slave  bus
);

  localparam int FW = (LOG2_AVG > 0) ? LOG2_AVG : 1;

  typedef enum logic {IDLE, SQ} state_t;

  state_t             state;
  state_t             state_nxt;
  logic signed [15:0] x [8];
  logic        [41:0] acc [8];
  logic      [FW-1:0] frame_cnt;
  logic         [2:0] band_cnt;

  logic               accept;
  logic               sq_step;
  logic               drop;
  logic               last_frame;
  logic signed [15:0] x_cur;
  logic signed [31:0] sq;
  logic        [41:0] sum;

  assign last_frame = (LOG2_AVG == 0) || (frame_cnt == {FW{1'b1}});
  assign x_cur      = x[band_cnt];
  assign sq         = x_cur * x_cur;
  // square is never negative, so zero-extension is exact
  assign sum        = acc[band_cnt] + {10'd0, sq};
  assign bus.busy   = (state == SQ);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sq_step   = 1'b0;
    drop      = 1'b0;
    if (bus.restart) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.din_valid) begin
            accept    = 1'b1;
            state_nxt = SQ;
          end
        end
        SQ: begin
          sq_step = 1'b1;
          drop    = bus.din_valid;
          if (band_cnt == 3'd7) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        x[i]   <= '0;
        acc[i] <= '0;
      end
      frame_cnt       <= '0;
      band_cnt        <= '0;
      bus.power_out   <= '0;
      bus.power_band  <= '0;
      bus.power_valid <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.power_valid <= 1'b0;
      if (bus.restart) begin
        for (int i = 0; i < 8; i++) begin
          acc[i] <= '0;
        end
        frame_cnt <= '0;
        band_cnt  <= '0;
      end else begin
        if (accept) begin
          x[0]     <= bus.datain0;
          x[1]     <= bus.datain1;
          x[2]     <= bus.datain2;
          x[3]     <= bus.datain3;
          x[4]     <= bus.datain4;
          x[5]     <= bus.datain5;
          x[6]     <= bus.datain6;
          x[7]     <= bus.datain7;
          band_cnt <= '0;
        end
        if (drop) begin
          bus.overrun <= 1'b1;
        end
        if (sq_step) begin
          band_cnt <= band_cnt + 3'd1;
          if (last_frame) begin
            // window sum is at most 2^40, so the shifted average fits 32 bits
            bus.power_out   <= 32'(sum >> LOG2_AVG);
            bus.power_band  <= band_cnt;
            bus.power_valid <= 1'b1;
            acc[band_cnt]   <= '0;
          end else begin
            acc[band_cnt]   <= sum;
          end
          if (band_cnt == 3'd7) begin
            frame_cnt <= last_frame ? '0 : frame_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_psd_band_power.sv
// Directed bench for psd_band_power: three instances (LOG2_AVG = 2, 0, 1)
// share one stimulus; each scenario checks the instance it targets.
`timescale 1ns/1ps
module tb_psd_band_power;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [15:0] d [8];
  logic               dv;
  logic               rs;
  int                 sel;
  int                 total = 0;
  int                 bad = 0;

  logic               pv;
  logic               bsy;
  logic               ov;
  logic        [31:0] po;
  logic         [2:0] pb;

  logic               cap_pv   [80];
  logic         [2:0] cap_pb   [80];
  logic        [31:0] cap_po   [80];
  logic               cap_busy [80];
  logic               busy0;
  int                 pv_count;
  logic        [31:0] exp_po [8];

  psd_band_power_if if_l2 ();
  psd_band_power_if if_l0 ();
  psd_band_power_if if_l1 ();

  psd_band_power #(.LOG2_AVG(2)) dut_l2 (.clock(clock), .reset(reset), .bus(if_l2));
  psd_band_power #(.LOG2_AVG(0)) dut_l0 (.clock(clock), .reset(reset), .bus(if_l0));
  psd_band_power #(.LOG2_AVG(1)) dut_l1 (.clock(clock), .reset(reset), .bus(if_l1));

  always #5 clock = ~clock;

  always_comb begin
    if_l2.datain0 = d[0]; if_l2.datain1 = d[1]; if_l2.datain2 = d[2]; if_l2.datain3 = d[3];
    if_l2.datain4 = d[4]; if_l2.datain5 = d[5]; if_l2.datain6 = d[6]; if_l2.datain7 = d[7];
    if_l2.din_valid = dv;
    if_l2.restart   = rs;
  end

  always_comb begin
    if_l0.datain0 = d[0]; if_l0.datain1 = d[1]; if_l0.datain2 = d[2]; if_l0.datain3 = d[3];
    if_l0.datain4 = d[4]; if_l0.datain5 = d[5]; if_l0.datain6 = d[6]; if_l0.datain7 = d[7];
    if_l0.din_valid = dv;
    if_l0.restart   = rs;
  end

  always_comb begin
    if_l1.datain0 = d[0]; if_l1.datain1 = d[1]; if_l1.datain2 = d[2]; if_l1.datain3 = d[3];
    if_l1.datain4 = d[4]; if_l1.datain5 = d[5]; if_l1.datain6 = d[6]; if_l1.datain7 = d[7];
    if_l1.din_valid = dv;
    if_l1.restart   = rs;
  end

  always_comb begin
    case (sel)
      0: begin
        pv = if_l2.power_valid; bsy = if_l2.busy; ov = if_l2.overrun;
        po = if_l2.power_out;   pb = if_l2.power_band;
      end
      1: begin
        pv = if_l0.power_valid; bsy = if_l0.busy; ov = if_l0.overrun;
        po = if_l0.power_out;   pb = if_l0.power_band;
      end
      default: begin
        pv = if_l1.power_valid; bsy = if_l1.busy; ov = if_l1.overrun;
        po = if_l1.power_out;   pb = if_l1.power_band;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < 8; k++) d[k] = 16'(v);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Pulse din_valid for one edge, then record outputs after each of the next edges.
  task automatic run_frame(input int cycles);
    dv = 1'b1;
    step();
    dv = 1'b0;
    busy0    = bsy;
    pv_count = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      cap_pv[i]   = pv;
      cap_pb[i]   = pb;
      cap_po[i]   = po;
      cap_busy[i] = bsy;
      if (pv) pv_count++;
    end
  endtask

  task automatic quiet_frames(input string tag, input int n);
    for (int f = 0; f < n; f++) begin
      run_frame(70);
      chk($sformatf("%s_quiet%0d", tag, f), 32'(pv_count), 32'd0);
    end
  endtask

  task automatic check_stream(input string tag);
    chk($sformatf("%s_count", tag), 32'(pv_count), 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_pv%0d", tag, k), 32'(cap_pv[k]), 32'd1);
      chk($sformatf("%s_band%0d", tag, k), 32'(cap_pb[k]), 32'(k));
      chk($sformatf("%s_po%0d", tag, k), cap_po[k], exp_po[k]);
    end
    chk($sformatf("%s_pv_after", tag), 32'(cap_pv[8]), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    dv    = 1'b0;
    rs    = 1'b0;
    sel   = 0;
    set_all(0);
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_pv", 32'(pv), 32'd0);
    chk("rst_po", po, 32'd0);
    chk("rst_pb", 32'(pb), 32'd0);
    chk("rst_ov", 32'(ov), 32'd0);

    // 4-frame window, single tone on band 0
    sel  = 0;
    d[0] = 16'sd100;
    quiet_frames("t1", 3);
    run_frame(70);
    exp_po = '{32'd10000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    check_stream("t1");

    // full-scale negative on every band, then zeros to prove clearing
    set_all(-32768);
    quiet_frames("t2a", 3);
    run_frame(70);
    for (int k = 0; k < 8; k++) exp_po[k] = 32'd1073741824;
    check_stream("t2a");
    set_all(0);
    quiet_frames("t2b", 3);
    run_frame(70);
    for (int k = 0; k < 8; k++) exp_po[k] = 32'd0;
    check_stream("t2b");

    // single-frame window with mixed-sign samples
    apply_reset();
    sel = 1;
    for (int k = 0; k < 8; k++) d[k] = 16'(k * 1000 - 3000);
    run_frame(70);
    chk("t3_busy_e0", 32'(busy0), 32'd1);
    chk("t3_busy_e7", 32'(cap_busy[6]), 32'd1);
    chk("t3_busy_e8", 32'(cap_busy[7]), 32'd0);
    exp_po = '{32'd9000000, 32'd4000000, 32'd1000000, 32'd0,
               32'd1000000, 32'd4000000, 32'd9000000, 32'd16000000};
    check_stream("t3");

    // overrun: second pulse at E4 is dropped and must not disturb the latch
    apply_reset();
    sel = 2;
    set_all(0);
    d[0] = 16'sd30;
    d[6] = 16'sd30;
    dv = 1'b1;
    step();
    dv = 1'b0;
    pv_count = 0;
    repeat (3) begin
      step();
      if (pv) pv_count++;
    end
    chk("t4_ov_before", 32'(ov), 32'd0);
    d[0] = 16'sd999;
    d[6] = 16'sd999;
    dv = 1'b1;
    step();
    dv = 1'b0;
    if (pv) pv_count++;
    chk("t4_ov_set", 32'(ov), 32'd1);
    repeat (65) begin
      step();
      if (pv) pv_count++;
    end
    chk("t4_quiet", 32'(pv_count), 32'd0);
    chk("t4_ov_sticky", 32'(ov), 32'd1);
    set_all(0);
    d[0] = 16'sd40;
    d[6] = 16'sd40;
    run_frame(70);
    exp_po = '{32'd1250, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1250, 32'd0};
    check_stream("t4");
    chk("t4_ov_end", 32'(ov), 32'd1);

    // restart discards a partial window; coincident din_valid is ignored
    apply_reset();
    sel = 0;
    set_all(0);
    d[0] = 16'sd200;
    quiet_frames("t5a", 2);
    rs = 1'b1;
    dv = 1'b1;
    step();
    rs = 1'b0;
    dv = 1'b0;
    chk("t5_busy", 32'(bsy), 32'd0);
    chk("t5_ov", 32'(ov), 32'd0);
    repeat (5) step();
    d[0] = 16'sd10;
    quiet_frames("t5b", 3);
    run_frame(70);
    exp_po = '{32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    check_stream("t5");

    // asynchronous reset in the middle of a result stream
    apply_reset();
    sel = 0;
    set_all(0);
    d[0] = 16'sd100;
    quiet_frames("t6a", 3);
    dv = 1'b1;
    step();
    dv = 1'b0;
    step();
    chk("t6_pv_b0", 32'(pv), 32'd1);
    chk("t6_po_b0", po, 32'd10000);
    dv = 1'b1;
    step();
    dv = 1'b0;
    chk("t6_ov", 32'(ov), 32'd1);
    step();
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_pv", 32'(pv), 32'd0);
    chk("t6_rst_busy", 32'(bsy), 32'd0);
    chk("t6_rst_ov", 32'(ov), 32'd0);
    chk("t6_rst_po", po, 32'd0);
    reset = 1'b1;
    pv_count = 0;
    repeat (70) begin
      step();
      if (pv) pv_count++;
    end
    chk("t6_no_tail", 32'(pv_count), 32'd0);
    d[0] = 16'sd50;
    quiet_frames("t6b", 3);
    run_frame(70);
    exp_po = '{32'd2500, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    check_stream("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psd_band_power.md
# psd_band_power

Per-band power estimator that sits directly downstream of the 8-channel FIR filter bank. Each time the bank presents a new set of eight 16-bit signed band outputs, the block squares each one and accumulates the result per band. One time-shared multiplier serves all eight bands. After 2^LOG2_AVG frames it emits the averaged power of each band as a serial stream of eight results, then starts the next averaging window.

## Interface
- LOG2_AVG, 6: log2 of the number of frames per averaging window; legal range 0..10.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- datain0..datain7  in  16 each  signed band samples from the filter bank.
- din_valid  in  1  one-cycle pulse; datain0..7 are valid on this cycle.
- restart  in  1  synchronous; discards the current averaging window.
- busy  out  1  high while a frame is being processed.
- power_out  out  32  unsigned averaged band power.
- power_band  out  3  band index (0..7) of power_out.
- power_valid  out  1  power_out and power_band are valid this cycle.
- overrun  out  1  sticky flag: a din_valid pulse was dropped.

## Operation
- Storage:
  - frame latch: eight 16-bit signed registers.
  - accumulators: eight 42-bit unsigned registers, acc[0..7].
  - frame counter: LOG2_AVG bits wide (one bit minimum).
  - band counter: 3 bits.
- States and transitions:
  - IDLE: when din_valid is high, latch datain0..7, clear the band counter, go to SQ.
  - SQ: lasts exactly 8 cycles and handles band k on SQ cycle k (k = 0..7). Leaves to IDLE after band 7.
- Arithmetic in SQ for band k:
  - sq = x[k]*x[k], a 16x16 signed product. It is always non-negative and at most 2^30 (reached for x = -32768).
  - Not the last frame of the window: acc[k] <= acc[k] + sq.
  - Last frame of the window (frame counter at all-ones, or LOG2_AVG = 0):
    - power_out <= (acc[k] + sq) >> LOG2_AVG, zero-extended to 32 bits; the maximum value is 2^30, so no saturation is needed.
    - power_band <= k; power_valid <= 1.
    - acc[k] <= 0.
- Frame counter increments on leaving SQ and wraps to 0 after the last frame of the window.
- din_valid while in SQ: the frame is dropped; overrun <= 1. Latch, counters and accumulators are unaffected. overrun clears only on reset.
- restart in any state:
  - next state IDLE; all acc, the frame counter and the band counter cleared; power_valid <= 0.
  - A din_valid on the same cycle is ignored and does not set overrun.
  - restart takes priority over everything except reset.
- Reset values: busy 0, power_out 0, power_band 0, power_valid 0, overrun 0, state IDLE, all accumulators and counters 0.

## Timing
- Edge E0 samples din_valid in IDLE.
- Edges E1..E8 process bands 0..7. busy is high from after E0 until after E8.
- Last frame of the window: power_valid is high for the 8 consecutive cycles following E1..E8, with power_band 0,1,...,7 in order. Latency from sampled din_valid to band 0 result is 1 cycle; to band 7 result is 8 cycles.
- power_valid is low in every other cycle. power_out holds its last value when power_valid is low.
- A din_valid at E8 is still in SQ: it counts as an overrun. The earliest accepted next frame is E9, so the minimum din_valid spacing is 9 cycles. The filter bank spacing of 60+ cycles is always met.
- Reset asserted mid-SQ: all outputs go to reset values immediately (asynchronously), with no partial result stream. After reset release, the block waits in IDLE for din_valid.

## Test plan
- LOG2_AVG=2; four frames with datain0=100, others 0, spaced 70 cycles -> no power_valid during frames 1-3; on frame 4, eight power_valid cycles with bands 0..7, band 0 = 10000, others 0.
- LOG2_AVG=2; four frames with all inputs -32768 -> every band reports 1073741824. A fifth through eighth frame with all inputs 0 -> every band reports 0, which proves the accumulators were cleared.
- LOG2_AVG=0; single frame, datainK = K*1000 - 3000 -> results 9000000, 4000000, 1000000, 0, 1000000, 4000000, 9000000, 16000000 for bands 0..7, appearing 1..8 cycles after din_valid.
- Overrun: din_valid at E0 and again at E4 -> overrun=1 from the cycle after E4 and stays high. With LOG2_AVG=1, the dropped frame does not count: results appear only after the next accepted frame.
- restart: LOG2_AVG=2, two frames of datain0=200, then a restart pulse, then four frames of datain0=10 -> band 0 = 100; the earlier frames contribute nothing.
- Async reset: reset low for 1 ns between E3 and E4 of a final frame -> power_valid, busy and overrun are 0 immediately and no further results appear. A subsequent full window reports correct values.
